// File: rtl/axis_governor_pkt.sv
// Packet-boundary AXI-Stream governor: pass, drop, log-tee and inject.
// Mode decisions are taken only in IDLE, so packets are never split.
`timescale 1ns/1ps
module axis_governor_pkt #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   in_TDATA,
  input  logic [DATA_WIDTH/8-1:0] in_TKEEP,
  input  logic [DEST_WIDTH-1:0]   in_TDEST,
  input  logic [ID_WIDTH-1:0]     in_TID,
  input  logic                    in_TLAST,
  input  logic                    in_TVALID,
  output logic                    in_TREADY,
  input  logic [DATA_WIDTH-1:0]   inj_TDATA,
  input  logic [DATA_WIDTH/8-1:0] inj_TKEEP,
  input  logic [DEST_WIDTH-1:0]   inj_TDEST,
  input  logic [ID_WIDTH-1:0]     inj_TID,
  input  logic                    inj_TLAST,
  input  logic                    inj_TVALID,
  output logic                    inj_TREADY,
  output logic [DATA_WIDTH-1:0]   out_TDATA,
  output logic [DATA_WIDTH/8-1:0] out_TKEEP,
  output logic [DEST_WIDTH-1:0]   out_TDEST,
  output logic [ID_WIDTH-1:0]     out_TID,
  output logic                    out_TLAST,
  output logic                    out_TVALID,
  input  logic                    out_TREADY,
  output logic [DATA_WIDTH-1:0]   log_TDATA,
  output logic [DATA_WIDTH/8-1:0] log_TKEEP,
  output logic [DEST_WIDTH-1:0]   log_TDEST,
  output logic [ID_WIDTH-1:0]     log_TID,
  output logic                    log_TLAST,
  output logic                    log_TVALID,
  input  logic                    log_TREADY,
  input  logic                    pause,
  input  logic                    drop,
  input  logic                    log,
  input  logic                    inject_en,
  output logic [1:0]              mode,
  output logic [CNT_WIDTH-1:0]    fwd_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic [CNT_WIDTH-1:0]    inj_cnt,
  output logic [CNT_WIDTH-1:0]    log_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2,
    S_INJ  = 2'd3
  } mode_e;

  mode_e mode_q, mode_d;
  logic  log_l_q, log_l_d;
  logic  out_done_q, out_done_d;
  logic  log_done_q, log_done_d;
  logic [CNT_WIDTH-1:0] fwd_q, fwd_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] inj_q, inj_d;
  logic [CNT_WIDTH-1:0] logc_q, logc_d;
  logic out_sdone;
  logic in_hs;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign log_TDATA = in_TDATA;
  assign log_TKEEP = in_TKEEP;
  assign log_TDEST = in_TDEST;
  assign log_TID   = in_TID;
  assign log_TLAST = in_TLAST;

  assign mode     = mode_q;
  assign fwd_cnt  = fwd_q;
  assign drop_cnt = drop_q;
  assign inj_cnt  = inj_q;
  assign log_cnt  = logc_q;

  always_comb begin
    mode_d     = mode_q;
    log_l_d    = log_l_q;
    out_done_d = out_done_q;
    log_done_d = log_done_q;
    fwd_d      = fwd_q;
    drop_d     = drop_q;
    inj_d      = inj_q;
    logc_d     = logc_q;
    in_TREADY  = 1'b0;
    inj_TREADY = 1'b0;
    out_TVALID = 1'b0;
    log_TVALID = 1'b0;
    out_TDATA  = in_TDATA;
    out_TKEEP  = in_TKEEP;
    out_TDEST  = in_TDEST;
    out_TID    = in_TID;
    out_TLAST  = in_TLAST;
    // DROP behaves as PASS with the out side already satisfied
    out_sdone  = out_done_q | (mode_q == S_DROP);
    in_hs      = 1'b0;
    unique case (mode_q)
      S_IDLE: begin
        if (inject_en && inj_TVALID) begin
          mode_d = S_INJ;
        end else if (!pause && in_TVALID) begin
          mode_d  = drop ? S_DROP : S_PASS;
          log_l_d = log;
        end
      end
      S_PASS, S_DROP: begin
        out_TVALID = in_TVALID & ~out_sdone;
        log_TVALID = in_TVALID & log_l_q & ~log_done_q;
        in_TREADY  = (out_sdone | out_TREADY)
                   & (~log_l_q | log_done_q | log_TREADY);
        in_hs      = in_TVALID & in_TREADY;
        if (in_hs) begin
          out_done_d = 1'b0;
          log_done_d = 1'b0;
          if (in_TLAST) begin
            mode_d  = S_IDLE;
            log_l_d = 1'b0;
            if (mode_q == S_PASS) fwd_d = sat_inc(fwd_q);
            else                  drop_d = sat_inc(drop_q);
            if (log_l_q) logc_d = sat_inc(logc_q);
          end
        end else begin
          if (out_TVALID && out_TREADY) out_done_d = 1'b1;
          if (log_TVALID && log_TREADY) log_done_d = 1'b1;
        end
      end
      S_INJ: begin
        out_TDATA  = inj_TDATA;
        out_TKEEP  = inj_TKEEP;
        out_TDEST  = inj_TDEST;
        out_TID    = inj_TID;
        out_TLAST  = inj_TLAST;
        out_TVALID = inj_TVALID;
        inj_TREADY = out_TREADY;
        if (inj_TVALID && out_TREADY && inj_TLAST) begin
          mode_d = S_IDLE;
          inj_d  = sat_inc(inj_q);
        end
      end
      default: mode_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q     <= S_IDLE;
      log_l_q    <= 1'b0;
      out_done_q <= 1'b0;
      log_done_q <= 1'b0;
      fwd_q      <= '0;
      drop_q     <= '0;
      inj_q      <= '0;
      logc_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      log_l_q    <= log_l_d;
      out_done_q <= out_done_d;
      log_done_q <= log_done_d;
      fwd_q      <= fwd_d;
      drop_q     <= drop_d;
      inj_q      <= inj_d;
      logc_q     <= logc_d;
    end
  end

endmodule

// File: tb/tb_axis_governor_pkt.sv
// Randomised bench for axis_governor_pkt: packet queues as reference,
// beat scoreboards per output side, counters modelled per packet.
`timescale 1ns/1ps
module tb_axis_governor_pkt;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  dest;
    logic [7:0]  id;
    logic        last;
  } beat_t;

  localparam logic [7:0] ID_IN  = 8'd1;
  localparam logic [7:0] ID_INJ = 8'd2;

  logic clk = 1'b0;
  logic aresetn;
  logic [63:0] in_TDATA, inj_TDATA, out_TDATA, log_TDATA;
  logic [7:0]  in_TKEEP, inj_TKEEP, out_TKEEP, log_TKEEP;
  logic [7:0]  in_TDEST, inj_TDEST, out_TDEST, log_TDEST;
  logic [7:0]  in_TID, inj_TID, out_TID, log_TID;
  logic in_TLAST, inj_TLAST, out_TLAST, log_TLAST;
  logic in_TVALID, inj_TVALID, out_TVALID, log_TVALID;
  logic in_TREADY, inj_TREADY, out_TREADY, log_TREADY;
  logic pause, drop, log, inject_en;
  logic [1:0]  mode;
  logic [31:0] fwd_cnt, drop_cnt, inj_cnt, log_cnt;

  logic [63:0] out_TDATA_2, log_TDATA_2;
  logic [7:0]  out_TKEEP_2, log_TKEEP_2, out_TDEST_2, log_TDEST_2;
  logic [7:0]  out_TID_2, log_TID_2;
  logic out_TLAST_2, log_TLAST_2, out_TVALID_2, log_TVALID_2;
  logic in_TREADY_2, inj_TREADY_2;
  logic [1:0] mode_2;
  logic [1:0] fwd_cnt_2, drop_cnt_2, inj_cnt_2, log_cnt_2;

  always #5 clk = ~clk;

  axis_governor_pkt dut (
    .clk(clk), .aresetn(aresetn),
    .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TDEST(in_TDEST),
    .in_TID(in_TID), .in_TLAST(in_TLAST), .in_TVALID(in_TVALID),
    .in_TREADY(in_TREADY),
    .inj_TDATA(inj_TDATA), .inj_TKEEP(inj_TKEEP), .inj_TDEST(inj_TDEST),
    .inj_TID(inj_TID), .inj_TLAST(inj_TLAST), .inj_TVALID(inj_TVALID),
    .inj_TREADY(inj_TREADY),
    .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TDEST(out_TDEST),
    .out_TID(out_TID), .out_TLAST(out_TLAST), .out_TVALID(out_TVALID),
    .out_TREADY(out_TREADY),
    .log_TDATA(log_TDATA), .log_TKEEP(log_TKEEP), .log_TDEST(log_TDEST),
    .log_TID(log_TID), .log_TLAST(log_TLAST), .log_TVALID(log_TVALID),
    .log_TREADY(log_TREADY),
    .pause(pause), .drop(drop), .log(log), .inject_en(inject_en),
    .mode(mode), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt),
    .inj_cnt(inj_cnt), .log_cnt(log_cnt)
  );

  axis_governor_pkt #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .aresetn(aresetn),
    .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TDEST(in_TDEST),
    .in_TID(in_TID), .in_TLAST(in_TLAST), .in_TVALID(in_TVALID),
    .in_TREADY(in_TREADY_2),
    .inj_TDATA(inj_TDATA), .inj_TKEEP(inj_TKEEP), .inj_TDEST(inj_TDEST),
    .inj_TID(inj_TID), .inj_TLAST(inj_TLAST), .inj_TVALID(inj_TVALID),
    .inj_TREADY(inj_TREADY_2),
    .out_TDATA(out_TDATA_2), .out_TKEEP(out_TKEEP_2),
    .out_TDEST(out_TDEST_2), .out_TID(out_TID_2),
    .out_TLAST(out_TLAST_2), .out_TVALID(out_TVALID_2),
    .out_TREADY(out_TREADY),
    .log_TDATA(log_TDATA_2), .log_TKEEP(log_TKEEP_2),
    .log_TDEST(log_TDEST_2), .log_TID(log_TID_2),
    .log_TLAST(log_TLAST_2), .log_TVALID(log_TVALID_2),
    .log_TREADY(log_TREADY),
    .pause(pause), .drop(drop), .log(log), .inject_en(inject_en),
    .mode(mode_2), .fwd_cnt(fwd_cnt_2), .drop_cnt(drop_cnt_2),
    .inj_cnt(inj_cnt_2), .log_cnt(log_cnt_2)
  );

  beat_t in_q[$], inj_q[$];
  beat_t exp_out[$], exp_log[$], exp_inj[$];
  logic [7:0] src_order[$];
  int n_chk = 0, n_err = 0;
  int fwd_m = 0, drop_m = 0, inj_m = 0, log_m = 0;
  int vprob = 100, rprob = 100;
  bit pause_rand = 0;
  bit out_mid = 0;
  logic [7:0] out_src = '0;
  bit in_hs, inj_hs;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] id,
                               input logic last);
    beat_t b;
    b.data = d;
    b.keep = 8'($urandom);
    b.dest = 8'($urandom);
    b.id   = id;
    b.last = last;
    return b;
  endfunction

  task automatic gen_pkt(input bit inj, input int len,
                         input bit to_out, input bit to_log);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b = mk({$urandom, $urandom}, inj ? ID_INJ : ID_IN, i == len - 1);
      if (inj) begin
        inj_q.push_back(b);
        exp_inj.push_back(b);
      end else begin
        in_q.push_back(b);
        if (to_out) exp_out.push_back(b);
        if (to_log) exp_log.push_back(b);
      end
    end
    if (inj) inj_m++;
    else begin
      if (to_out) fwd_m++;
      else        drop_m++;
      if (to_log) log_m++;
    end
  endtask

  task automatic see_out(input beat_t ob);
    if (!out_mid) src_order.push_back(ob.id);
    else chk("no_interleave", 128'(ob.id), 128'(out_src));
    out_src = ob.id;
    out_mid = !ob.last;
    if (ob.id == ID_INJ) begin
      if (exp_inj.size() == 0) chk("inj_extra", 128'(1), 128'(0));
      else chk("inj_beat", 128'(ob), 128'(exp_inj.pop_front()));
    end else begin
      if (exp_out.size() == 0) chk("out_extra", 128'(1), 128'(0));
      else chk("out_beat", 128'(ob), 128'(exp_out.pop_front()));
    end
  endtask

  task automatic see_log(input beat_t lb);
    if (exp_log.size() == 0) chk("log_extra", 128'(1), 128'(0));
    else chk("log_beat", 128'(lb), 128'(exp_log.pop_front()));
  endtask

  // Called at a negedge: drive, sample, let the posedge pass.
  task automatic tick();
    if (!in_TVALID && in_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
      in_TVALID = 1'b1;
      {in_TDATA, in_TKEEP, in_TDEST, in_TID, in_TLAST} = in_q[0];
    end
    if (!inj_TVALID && inj_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
      inj_TVALID = 1'b1;
      {inj_TDATA, inj_TKEEP, inj_TDEST, inj_TID, inj_TLAST} = inj_q[0];
    end
    out_TREADY = int'($urandom_range(99)) < rprob;
    log_TREADY = int'($urandom_range(99)) < rprob;
    if (pause_rand) pause = 1'($urandom_range(1));
    #1;
    in_hs  = in_TVALID && in_TREADY;
    inj_hs = inj_TVALID && inj_TREADY;
    if (out_TVALID && out_TREADY)
      see_out({out_TDATA, out_TKEEP, out_TDEST, out_TID, out_TLAST});
    if (log_TVALID && log_TREADY)
      see_log({log_TDATA, log_TKEEP, log_TDEST, log_TID, log_TLAST});
    @(negedge clk);
    if (in_hs) begin
      void'(in_q.pop_front());
      in_TVALID = 1'b0;
    end
    if (inj_hs) begin
      void'(inj_q.pop_front());
      inj_TVALID = 1'b0;
    end
  endtask

  function automatic bit busy();
    return in_q.size() > 0 || inj_q.size() > 0 || exp_out.size() > 0
        || exp_log.size() > 0 || exp_inj.size() > 0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 128'(busy()), 128'(0));
  endtask

  task automatic check_counters(input string tag);
    int sat;
    sat = fwd_m > 3 ? 3 : fwd_m;
    chk({tag, "_fwd"},  128'(fwd_cnt),  128'(fwd_m));
    chk({tag, "_drop"}, 128'(drop_cnt), 128'(drop_m));
    chk({tag, "_inj"},  128'(inj_cnt),  128'(inj_m));
    chk({tag, "_log"},  128'(log_cnt),  128'(log_m));
    chk({tag, "_fwd_sat"}, 128'(fwd_cnt_2), 128'(sat));
    chk({tag, "_mode"}, 128'(mode), 128'(0));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_rdy"},  128'(in_TREADY),  128'(0));
    chk({tag, "_inj_rdy"}, 128'(inj_TREADY), 128'(0));
    chk({tag, "_out_vld"}, 128'(out_TVALID), 128'(0));
    chk({tag, "_log_vld"}, 128'(log_TVALID), 128'(0));
    chk({tag, "_mode"},    128'(mode),       128'(0));
    chk({tag, "_cnts"},
        128'({fwd_cnt, drop_cnt, inj_cnt, log_cnt}), 128'(0));
    chk({tag, "_cnts2"},
        128'({fwd_cnt_2, drop_cnt_2, inj_cnt_2, log_cnt_2}), 128'(0));
  endtask

  initial begin
    int tries;
    logic [7:0] o0, o1;
    aresetn = 1'b0;
    {in_TDATA, in_TKEEP, in_TDEST, in_TID, in_TLAST, in_TVALID} = '0;
    {inj_TDATA, inj_TKEEP, inj_TDEST, inj_TID, inj_TLAST, inj_TVALID} = '0;
    out_TREADY = 1'b0;
    log_TREADY = 1'b0;
    {pause, drop, log, inject_en} = '0;
    repeat (3) @(negedge clk);
    in_TVALID = 1'b1;
    #1;
    check_reset("reset");
    in_TVALID = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // directed PASS packet 1,3,5,7
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b = mk(64'(2 * i + 1), ID_IN, i == 3);
      in_q.push_back(b);
      exp_out.push_back(b);
    end
    fwd_m++;
    drain("pass4", 100);
    check_counters("pass4");

    // PASS with log, random readies and gaps
    log = 1'b1;
    vprob = 70;
    rprob = 60;
    for (int p = 0; p < 100; p++) gen_pkt(0, $urandom_range(1, 16), 1, 1);
    drain("passlog", 20000);
    check_counters("passlog");

    // DROP without and with log
    vprob = 100;
    rprob = 100;
    drop = 1'b1;
    log = 1'b0;
    gen_pkt(0, 3, 0, 0);
    drain("drop", 100);
    check_counters("drop");
    log = 1'b1;
    gen_pkt(0, 3, 0, 1);
    drain("droplog", 100);
    check_counters("droplog");
    vprob = 80;
    rprob = 50;
    for (int p = 0; p < 20; p++) gen_pkt(0, $urandom_range(1, 8), 0, 1);
    drain("droprnd", 5000);
    check_counters("droprnd");
    drop = 1'b0;
    log = 1'b0;

    // pause holds off the packet
    vprob = 100;
    rprob = 100;
    pause = 1'b1;
    gen_pkt(0, 5, 1, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_rdy", 128'(in_TREADY), 128'(0));
      chk("pause_mode", 128'(mode), 128'(0));
    end
    pause_rand = 1'b1;
    drain("pausetgl", 500);
    pause_rand = 1'b0;
    pause = 1'b0;
    check_counters("pausetgl");

    // inject wins when both valid
    inject_en = 1'b1;
    src_order.delete();
    gen_pkt(0, 4, 1, 0);
    gen_pkt(1, 3, 0, 0);
    drain("injprio", 200);
    o0 = src_order.size() > 0 ? src_order[0] : 8'hff;
    o1 = src_order.size() > 1 ? src_order[1] : 8'hff;
    chk("injprio_first", 128'(o0), 128'(ID_INJ));
    chk("injprio_second", 128'(o1), 128'(ID_IN));
    check_counters("injprio");

    // inject_en raised mid in-packet: no interleave
    inject_en = 1'b0;
    src_order.delete();
    gen_pkt(0, 6, 1, 0);
    gen_pkt(1, 2, 0, 0);
    tries = 0;
    while (in_q.size() > 5 && tries < 50) begin
      tick();
      tries++;
    end
    chk("injmid_start", 128'(tries < 50), 128'(1));
    inject_en = 1'b1;
    drain("injmid", 200);
    o0 = src_order.size() > 0 ? src_order[0] : 8'hff;
    o1 = src_order.size() > 1 ? src_order[1] : 8'hff;
    chk("injmid_first", 128'(o0), 128'(ID_IN));
    chk("injmid_second", 128'(o1), 128'(ID_INJ));
    check_counters("injmid");
    inject_en = 1'b0;

    // reset in the middle of a PASS packet
    gen_pkt(0, 8, 1, 0);
    tries = 0;
    while (in_q.size() > 5 && tries < 50) begin
      tick();
      tries++;
    end
    chk("rstmid_start", 128'(mode), 128'(1));
    aresetn = 1'b0;
    in_TVALID = 1'b1;
    #1;
    check_reset("rstmid");
    in_q.delete();
    exp_out.delete();
    exp_log.delete();
    exp_inj.delete();
    in_TVALID = 1'b0;
    out_mid = 1'b0;
    {fwd_m, drop_m, inj_m, log_m} = '0;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // five packets: 2-bit counter must saturate at 3
    rprob = 70;
    for (int p = 0; p < 5; p++) gen_pkt(0, $urandom_range(1, 6), 1, 0);
    drain("sat", 2000);
    check_counters("sat");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
